// File: rtl/matrix_inv_pkg.sv
// Shared types and helpers for the sequential fraction-free matrix inverter.
package matrix_inv_pkg;

  localparam int unsigned DW_DEFAULT = 32;

  // Element type at the default width. The modules are parameterised on DW,
  // so internally they size their own vectors from DW.
  typedef logic signed [DW_DEFAULT-1:0] elem_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SEARCH,
    S_SWAP,
    S_ELIM,
    S_DONE
  } state_t;

  // One element of an identity row: 1 on the diagonal, 0 elsewhere.
  function automatic logic ident_bit(input int unsigned row, input int unsigned col);
    return row == col;
  endfunction

endpackage

// File: rtl/matrix_row_combine.sv
// Combinational row update: new_row = p*row_i - f*row_k over all 2N columns.
// Products and the difference are formed at 2*DW+1 bits and wrapped to DW.
module matrix_row_combine #(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 32
) (
  input  logic [DW-1:0]     i_p,
  input  logic [DW-1:0]     i_f,
  input  logic [2*N*DW-1:0] i_row_i,
  input  logic [2*N*DW-1:0] i_row_k,
  output logic [2*N*DW-1:0] o_new_row,
  output logic              o_ovf_any
);

  localparam int unsigned XW = 2*DW + 1;

  // True when a wide result does not fit the DW-bit signed range.
  function automatic logic f_oor(input logic signed [XW-1:0] x);
    return !((&x[XW-1:DW-1]) || (~|x[XW-1:DW-1]));
  endfunction

  logic signed [XW-1:0] w_ps;
  logic signed [XW-1:0] w_fs;
  logic [2*N-1:0]       w_col_ovf;

  assign w_ps = XW'($signed(i_p));
  assign w_fs = XW'($signed(i_f));

  for (genvar j = 0; j < 2*N; j++) begin : g_col
    logic signed [XW-1:0] w_ai;
    logic signed [XW-1:0] w_bk;
    logic signed [XW-1:0] w_pa;
    logic signed [XW-1:0] w_fb;
    logic signed [XW-1:0] w_diff;

    assign w_ai   = XW'($signed(i_row_i[j*DW +: DW]));
    assign w_bk   = XW'($signed(i_row_k[j*DW +: DW]));
    assign w_pa   = w_ps * w_ai;
    assign w_fb   = w_fs * w_bk;
    assign w_diff = w_pa - w_fb;

    assign w_col_ovf[j]            = f_oor(w_pa) | f_oor(w_fb) | f_oor(w_diff);
    assign o_new_row[j*DW +: DW]   = w_diff[DW-1:0];
  end

  assign o_ovf_any = |w_col_ovf;

endmodule

// File: rtl/matrix_inverse_seq.sv
// Multi-cycle N x N fraction-free Gauss-Jordan inverter with row-swap pivoting.
// Result: inv[i][j] = num[i][j] / den[i], num = right half R, den[i] = L[i][i].
module matrix_inverse_seq
  import matrix_inv_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 32,
  parameter int unsigned AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic          ovf,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_num,
  output logic [DW-1:0] rd_den
);

  localparam int unsigned    KW     = $clog2(N);
  localparam logic [KW-1:0]  LAST   = KW'(N-1);
  localparam logic [KW-1:0]  PENULT = KW'(N-2);
  localparam logic [AW-1:0]  NA     = AW'(N);

  // Augmented storage [L | R], each row packed with column j at bits j*DW.
  logic [N-1:0][N-1:0][DW-1:0] r_lh;
  logic [N-1:0][N-1:0][DW-1:0] r_rh;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [KW-1:0] r_i;
  logic [KW-1:0] r_row;
  logic          r_busy;
  logic          r_done;
  logic          r_sing;
  logic          r_ovf;

  logic [KW-1:0]               w_ld_row;
  logic [KW-1:0]               w_ld_col;
  logic [KW-1:0]               w_rd_row;
  logic [KW-1:0]               w_rd_col;
  logic [2*N*DW-1:0]           w_row_i;
  logic [2*N*DW-1:0]           w_row_k;
  logic [2*N*DW-1:0]           w_new_row;
  logic                        w_ovf_any;
  logic [DW-1:0]               w_p;
  logic [DW-1:0]               w_f;
  logic                        w_pivot_nz;
  logic                        w_last_i;
  logic [KW-1:0]               w_first_i;
  logic [KW-1:0]               w_next_i;
  logic [N-1:0][N-1:0][DW-1:0] w_ident;

  assign w_ld_row = KW'(ld_addr / NA);
  assign w_ld_col = KW'(ld_addr % NA);
  assign w_rd_row = KW'(rd_addr / NA);
  assign w_rd_col = KW'(rd_addr % NA);

  // Operands for the shared row combiner: row i against pivot row k.
  assign w_row_i    = {r_rh[r_i], r_lh[r_i]};
  assign w_row_k    = {r_rh[r_k], r_lh[r_k]};
  assign w_p        = r_lh[r_k][r_k];
  assign w_f        = r_lh[r_i][r_k];
  assign w_pivot_nz = |r_lh[r_row][r_k];

  // ELIM walks i = 0..N-1 skipping k; the last visited row depends on whether k is N-1.
  assign w_first_i = (r_k == '0) ? KW'(1) : '0;
  assign w_next_i  = (r_i + KW'(1) == r_k) ? r_i + KW'(2) : r_i + KW'(1);
  assign w_last_i  = (r_i == LAST) || ((r_i == PENULT) && (r_k == LAST));

  // Identity matrix for initialising R.
  always_comb begin
    w_ident = '0;
    for (int unsigned a = 0; a < N; a++) begin
      for (int unsigned b = 0; b < N; b++) begin
        w_ident[a][b] = DW'(ident_bit(a, b));
      end
    end
  end

  matrix_row_combine #(
    .N  (N),
    .DW (DW)
  ) u_comb (
    .i_p       (w_p),
    .i_f       (w_f),
    .i_row_i   (w_row_i),
    .i_row_k   (w_row_k),
    .o_new_row (w_new_row),
    .o_ovf_any (w_ovf_any)
  );

  // Control FSM, counters, storage updates and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lh    <= '0;
      r_rh    <= '0;
      r_k     <= '0;
      r_i     <= '0;
      r_row   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sing  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (ld_valid) begin
            r_lh[w_ld_row][w_ld_col] <= ld_data;
          end
          if (start) begin
            r_busy  <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_rh    <= w_ident;
          r_k     <= '0;
          r_row   <= '0;
          r_sing  <= 1'b0;
          r_ovf   <= 1'b0;
          r_state <= S_SEARCH;
        end
        S_SEARCH: begin
          if (w_pivot_nz) begin
            r_i     <= w_first_i;
            r_state <= (r_row == r_k) ? S_ELIM : S_SWAP;
          end else if (r_row == LAST) begin
            r_sing  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_row <= r_row + KW'(1);
          end
        end
        S_SWAP: begin
          r_lh[r_row] <= r_lh[r_k];
          r_lh[r_k]   <= r_lh[r_row];
          r_rh[r_row] <= r_rh[r_k];
          r_rh[r_k]   <= r_rh[r_row];
          r_state     <= S_ELIM;
        end
        S_ELIM: begin
          r_lh[r_i] <= w_new_row[N*DW-1:0];
          r_rh[r_i] <= w_new_row[2*N*DW-1:N*DW];
          if (w_ovf_any) begin
            r_ovf <= 1'b1;
          end
          if (w_last_i) begin
            if (r_k == LAST) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k + KW'(1);
              r_row   <= r_k + KW'(1);
              r_state <= S_SEARCH;
            end
          end else begin
            r_i <= w_next_i;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign singular = r_sing;
  assign ovf      = r_ovf;

  assign rd_num = r_busy ? '0 : r_rh[w_rd_row][w_rd_col];
  assign rd_den = r_busy ? '0 : r_lh[w_rd_row][w_rd_row];

endmodule

// File: tb/tb_matrix_inverse_seq.sv
// Self-checking bench: three inverter instances (N=5/DW=32, N=2/DW=32, N=2/DW=8)
// compared against a plain-arithmetic Gauss-Jordan reference model.
module tb_matrix_inverse_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ld_valid [3];
  logic        start    [3];
  logic [4:0]  ld_addr  [3];
  logic [4:0]  rd_addr  [3];
  logic [31:0] ld_data  [3];

  logic        busy_a, done_a, sing_a, ovf_a;
  logic        busy_b, done_b, sing_b, ovf_b;
  logic        busy_c, done_c, sing_c, ovf_c;
  logic [31:0] num_a, den_a, num_b, den_b;
  logic [7:0]  num_c, den_c;

  logic        o_busy [3];
  logic        o_done [3];
  logic        o_sing [3];
  logic        o_ovf  [3];
  logic [31:0] o_num  [3];
  logic [31:0] o_den  [3];

  int n_checks = 0;
  int n_fail   = 0;

  longint mat     [5][5];
  longint exp_num [5][5];
  longint exp_den [5];
  bit     exp_sing;
  bit     exp_ovf;
  int     exp_lat;

  matrix_inverse_seq #(.N(5), .DW(32)) dut_a (
    .clk(clk), .reset(reset), .ld_valid(ld_valid[0]), .ld_addr(ld_addr[0]),
    .ld_data(ld_data[0]), .start(start[0]), .busy(busy_a), .done(done_a),
    .singular(sing_a), .ovf(ovf_a), .rd_addr(rd_addr[0]), .rd_num(num_a), .rd_den(den_a)
  );

  matrix_inverse_seq #(.N(2), .DW(32)) dut_b (
    .clk(clk), .reset(reset), .ld_valid(ld_valid[1]), .ld_addr(ld_addr[1][1:0]),
    .ld_data(ld_data[1]), .start(start[1]), .busy(busy_b), .done(done_b),
    .singular(sing_b), .ovf(ovf_b), .rd_addr(rd_addr[1][1:0]), .rd_num(num_b), .rd_den(den_b)
  );

  matrix_inverse_seq #(.N(2), .DW(8)) dut_c (
    .clk(clk), .reset(reset), .ld_valid(ld_valid[2]), .ld_addr(ld_addr[2][1:0]),
    .ld_data(ld_data[2][7:0]), .start(start[2]), .busy(busy_c), .done(done_c),
    .singular(sing_c), .ovf(ovf_c), .rd_addr(rd_addr[2][1:0]), .rd_num(num_c), .rd_den(den_c)
  );

  always_comb begin
    o_busy[0] = busy_a; o_busy[1] = busy_b; o_busy[2] = busy_c;
    o_done[0] = done_a; o_done[1] = done_b; o_done[2] = done_c;
    o_sing[0] = sing_a; o_sing[1] = sing_b; o_sing[2] = sing_c;
    o_ovf[0]  = ovf_a;  o_ovf[1]  = ovf_b;  o_ovf[2]  = ovf_c;
    o_num[0]  = num_a;  o_num[1]  = num_b;  o_num[2]  = {{24{num_c[7]}}, num_c};
    o_den[0]  = den_a;  o_den[1]  = den_b;  o_den[2]  = {{24{den_c[7]}}, den_c};
  end

  function automatic int nd(input int d);
    return (d == 0) ? 5 : 2;
  endfunction

  function automatic int dwd(input int d);
    return (d == 2) ? 8 : 32;
  endfunction

  function automatic longint wrap(input logic signed [127:0] x, input int dw);
    logic signed [127:0] y;
    y = x <<< (128 - dw);
    y = y >>> (128 - dw);
    return y[63:0];
  endfunction

  function automatic bit oor(input logic signed [127:0] x, input int dw);
    logic signed [127:0] lim;
    lim = 128'sd1 <<< (dw - 1);
    return (x > lim - 1) || (x < -lim);
  endfunction

  // Reference: fraction-free Gauss-Jordan on [A | I] with wrap-to-DW arithmetic,
  // also tallying the cycle on which done is expected.
  task automatic model(input int d);
    int n, dw, r;
    bit found;
    longint m [5][10];
    longint p, f;
    logic signed [127:0] pa, fb, df;
    n = nd(d); dw = dwd(d);
    exp_sing = 0; exp_ovf = 0; exp_lat = 1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 2*n; j++)
        m[i][j] = (j < n) ? wrap(128'(mat[i][j]), dw) : longint'((j - n) == i);
    for (int k = 0; k < n; k++) begin
      found = 0; r = k;
      while (r < n && !found) begin
        exp_lat++;
        if (m[r][k] != 0) found = 1; else r++;
      end
      if (!found) begin
        exp_sing = 1;
        break;
      end
      if (r != k) begin
        exp_lat++;
        for (int j = 0; j < 2*n; j++) begin
          p = m[r][j]; m[r][j] = m[k][j]; m[k][j] = p;
        end
      end
      for (int i = 0; i < n; i++) begin
        if (i == k) continue;
        exp_lat++;
        p = m[k][k]; f = m[i][k];
        for (int j = 0; j < 2*n; j++) begin
          pa = 128'(p) * 128'(m[i][j]);
          fb = 128'(f) * 128'(m[k][j]);
          df = pa - fb;
          if (oor(pa, dw) || oor(fb, dw) || oor(df, dw)) exp_ovf = 1;
          m[i][j] = wrap(df, dw);
        end
      end
    end
    exp_lat++;
    for (int i = 0; i < n; i++) begin
      exp_den[i] = m[i][i];
      for (int j = 0; j < n; j++) exp_num[i][j] = m[i][n+j];
    end
  endtask

  // Loads mat into DUT d; the final element is written together with start.
  // Returns #1 after the edge that accepted start.
  task automatic load_start(input int d);
    int n;
    n = nd(d);
    @(negedge clk);
    for (int e = 0; e < n*n - 1; e++) begin
      ld_valid[d] = 1'b1; ld_addr[d] = 5'(e); ld_data[d] = 32'(mat[e/n][e%n]);
      @(negedge clk);
    end
    ld_valid[d] = 1'b1; ld_addr[d] = 5'(n*n - 1); ld_data[d] = 32'(mat[n-1][n-1]);
    start[d] = 1'b1;
    @(posedge clk); #1;
    ld_valid[d] = 1'b0; start[d] = 1'b0;
  endtask

  task automatic run(input int d, input bit glitch, input string tag);
    int n, cyc;
    n = nd(d);
    model(d);
    load_start(d);
    cyc = 1;
    n_checks++;
    if (o_busy[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_after_start: got %b want 1", tag, o_busy[d]);
    end
    while (o_done[d] !== 1'b1 && cyc < 400) begin
      if (glitch && cyc == 3) begin
        ld_valid[d] = 1'b1; ld_addr[d] = 5'd0; ld_data[d] = 32'd123; start[d] = 1'b1;
      end else if (glitch && cyc == 4) begin
        ld_valid[d] = 1'b0; start[d] = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    ld_valid[d] = 1'b0; start[d] = 1'b0;
    n_checks++;
    if (cyc >= 400) begin
      n_fail++; $display("FAIL %s done_timeout: got no done within %0d cycles want done", tag, cyc);
      return;
    end
    n_checks++;
    if (cyc != exp_lat) begin
      n_fail++; $display("FAIL %s latency: got cycle %0d want cycle %0d", tag, cyc, exp_lat);
    end
    n_checks++;
    if (o_sing[d] !== exp_sing) begin
      n_fail++; $display("FAIL %s singular: got %b want %b", tag, o_sing[d], exp_sing);
    end
    n_checks++;
    if (o_ovf[d] !== exp_ovf) begin
      n_fail++; $display("FAIL %s ovf: got %b want %b", tag, o_ovf[d], exp_ovf);
    end
    n_checks++;
    if (o_busy[d] !== 1'b1) begin
      n_fail++; $display("FAIL %s busy_in_done: got %b want 1", tag, o_busy[d]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (o_busy[d] !== 1'b0 || o_done[d] !== 1'b0) begin
      n_fail++; $display("FAIL %s idle_after_done: got busy=%b done=%b want 0 0", tag, o_busy[d], o_done[d]);
    end
    for (int e = 0; e < n*n; e++) begin
      rd_addr[d] = 5'(e); #1;
      n_checks++;
      if (o_num[d] !== 32'(exp_num[e/n][e%n])) begin
        n_fail++; $display("FAIL %s num[%0d]: got %0d want %0d", tag, e, $signed(o_num[d]), exp_num[e/n][e%n]);
      end
      n_checks++;
      if (o_den[d] !== 32'(exp_den[e/n])) begin
        n_fail++; $display("FAIL %s den[%0d]: got %0d want %0d", tag, e, $signed(o_den[d]), exp_den[e/n]);
      end
    end
  endtask

  task automatic set2(input longint a00, input longint a01, input longint a10, input longint a11);
    mat[0][0] = a00; mat[0][1] = a01; mat[1][0] = a10; mat[1][1] = a11;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rd_addr[d] = 5'd0; #1;
      n_checks++;
      if (o_busy[d] !== 1'b0 || o_done[d] !== 1'b0 || o_sing[d] !== 1'b0 || o_ovf[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_flags dut%0d: got %b%b%b%b want 0000", d, o_busy[d], o_done[d], o_sing[d], o_ovf[d]);
      end
      n_checks++;
      if (o_num[d] !== 32'd0 || o_den[d] !== 32'd0) begin
        n_fail++; $display("FAIL reset_read dut%0d: got num=%0d den=%0d want 0 0", d, o_num[d], o_den[d]);
      end
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) mat[i][j] = (i == j) ? 1 : 0;
    run(0, 0, "identity5");
  endtask

  task automatic test_inverse_2x2();
    set2(2, 1, 1, 1);
    run(1, 0, "inv2x2");
  endtask

  task automatic test_swap_2x2();
    set2(0, 1, 1, 0);
    run(1, 0, "swap2x2");
  endtask

  task automatic test_singular_2x2();
    set2(1, 2, 2, 4);
    run(1, 0, "singular2x2");
  endtask

  task automatic test_overflow_dw8();
    set2(100, 1, 1, 100);
    run(2, 0, "ovf_dw8");
    set2(3, 1, 2, 5);
    run(2, 0, "dw8_noovf");
  endtask

  task automatic test_busy_ignored();
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) mat[i][j] = longint'($urandom_range(0, 6)) - 3;
    run(0, 1, "busy_ignored5");
    set2(3, -2, 5, 7);
    run(1, 1, "busy_ignored2");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++) mat[i][j] = longint'($urandom_range(0, 6)) - 3;
      if (t % 3 == 0) mat[0][0] = 0;
      run(0, 0, "random5");
    end
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++) mat[i][j] = longint'($urandom_range(0, 100)) - 50;
      if (t % 2 == 0) mat[0][0] = 0;
      run(1, 0, "random2");
      run(2, 0, "random2_dw8");
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) mat[i][j] = (i == j) ? 1 : 0;
    load_start(0);
    // After 13 more edges the engine sits in ELIM for k = 2 (cycles 13..16).
    repeat (13) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (o_busy[0] !== 1'b0 || o_done[0] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: got busy=%b done=%b want 0 0", o_busy[0], o_done[0]);
    end
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (o_done[0] === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_no_done: got %0d done pulses want 0", seen);
    end
    n_checks++;
    if (o_sing[0] !== 1'b0 || o_ovf[0] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_status: got sing=%b ovf=%b want 0 0", o_sing[0], o_ovf[0]);
    end
    for (int e = 0; e < 25; e++) begin
      rd_addr[0] = 5'(e); #1;
      n_checks++;
      if (o_num[0] !== 32'd0 || o_den[0] !== 32'd0) begin
        n_fail++; $display("FAIL midreset_read[%0d]: got num=%0d den=%0d want 0 0", e, o_num[0], o_den[0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      ld_valid[d] = 1'b0; start[d] = 1'b0; ld_addr[d] = '0; rd_addr[d] = '0; ld_data[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_identity();
    test_inverse_2x2();
    test_swap_2x2();
    test_singular_2x2();
    test_overflow_dw8();
    test_busy_ignored();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
